// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU ops, mux selects, FSM states.
// ALU_* values must track the ALU's own decode; they leave the block unchanged in EXEC_R.
package multicycle_control_unit_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts consecutive cycles a memory request goes unanswered; flags timeout combinationally
// on the MEM_TIMEOUT-th such cycle. A ready on that same cycle suppresses the flag.
module multicycle_control_unit_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         stalled;

  assign stalled = waiting && !mem_ready;

  always_comb begin
    cnt_d = '0;
    if (stalled) cnt_d = cnt_q + 1'b1;
  end

  // cnt_q holds the number of stalled cycles before this one
  assign timeout = stalled && (cnt_q >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the 16-bit multi-cycle datapath (fetch/decode/execute/memory/writeback).
// Zero-wait latency: R/ADDI/SW 4, LW 5, branch/jump 3 cycles; memory stalls hold the state.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             input_CLK,
  input  logic             input_Reset_n,
  input  logic [3:0]       input_Opcode,
  input  logic             input_Zero,
  input  logic             input_MemReady,
  output logic [2:0]       output_ALUOp,
  output logic             output_ALUSrcA,
  output logic [1:0]       output_ALUSrcB,
  output logic             output_PCWrite,
  output logic [1:0]       output_PCSrc,
  output logic             output_IRWrite,
  output logic             output_MemReq,
  output logic             output_MemWrite,
  output logic             output_IorD,
  output logic             output_RegWrite,
  output logic             output_MemtoReg,
  output logic             output_RegDst,
  output logic             output_Halted,
  output logic             output_Illegal,
  output logic             output_BusError,
  output logic [CNT_W-1:0] output_InstrCount,
  output logic [3:0]       output_State
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             retire;
  logic             waiting;
  logic             timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  multicycle_control_unit_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (input_CLK),
    .rst_n    (input_Reset_n),
    .waiting  (waiting),
    .mem_ready(input_MemReady),
    .timeout  (timeout)
  );

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    illegal_d       = illegal_q;
    bus_err_d       = bus_err_q;
    retire          = 1'b0;
    output_ALUOp    = ALU_ADD;
    output_ALUSrcA  = 1'b0;
    output_ALUSrcB  = SRCB_REGB;
    output_PCWrite  = 1'b0;
    output_PCSrc    = PCSRC_ALU;
    output_IRWrite  = 1'b0;
    output_MemReq   = 1'b0;
    output_MemWrite = 1'b0;
    output_IorD     = 1'b0;
    output_RegWrite = 1'b0;
    output_MemtoReg = 1'b0;
    output_RegDst   = 1'b0;
    output_Halted   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        output_MemReq  = 1'b1;
        output_ALUSrcB = SRCB_ONE;
        output_IRWrite = input_MemReady;
        output_PCWrite = input_MemReady;
        if (input_MemReady) state_d = S_DECODE;
        else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        output_ALUSrcB = SRCB_IMM;
        op_d           = input_Opcode;
        if (is_rtype(input_Opcode)) state_d = S_EXEC_R;
        else begin
          case (input_Opcode)
            OP_ADDI:        state_d = S_EXEC_I;
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_HALT:        state_d = S_HALT;
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_REGB;
        output_ALUOp   = op_q[2:0];
        state_d        = S_ALU_WB;
      end
      S_EXEC_I: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_IMM;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        output_RegWrite = 1'b1;
        output_RegDst   = is_rtype(op_q);
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_MEM_ADDR: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_IMM;
        state_d        = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        output_MemReq = 1'b1;
        output_IorD   = 1'b1;
        if (input_MemReady) state_d = S_MEM_WB;
        else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WB: begin
        output_RegWrite = 1'b1;
        output_MemtoReg = 1'b1;
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_MEM_WR: begin
        output_MemReq   = 1'b1;
        output_MemWrite = 1'b1;
        output_IorD     = 1'b1;
        if (input_MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_BRANCH: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = SRCB_REGB;
        output_ALUOp   = ALU_SUB;
        output_PCSrc   = PCSRC_ALUOUT;
        output_PCWrite = ((op_q == OP_BEQ) && input_Zero) || ((op_q == OP_BNE) && !input_Zero);
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_JUMP: begin
        output_PCWrite = 1'b1;
        output_PCSrc   = PCSRC_JUMP;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_HALT: output_Halted = 1'b1;
      default: state_d = S_IDLE;
    endcase

    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign output_Illegal    = illegal_q;
  assign output_BusError   = bus_err_q;
  assign output_InstrCount = cnt_q;
  assign output_State      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit; inputs change and outputs are sampled in the clock-low phase.
module tb_multicycle_control_unit;

  localparam int CNT_W = 16;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC_R = 4'd3;
  localparam logic [3:0] ST_ALU_WB = 4'd5, ST_MEM_ADDR = 4'd6, ST_MEM_RD = 4'd7, ST_MEM_WB = 4'd8;
  localparam logic [3:0] ST_MEM_WR = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11, ST_HALT = 4'd12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       opcode = 4'h0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic [2:0]       alu_op;
  logic             src_a;
  logic [1:0]       src_b;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write, mem_req, mem_write, iord, reg_write, memto_reg, reg_dst;
  logic             halted, illegal, bus_err;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state;

  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  logic [63:0] got, exp;

  logic [3:0] b_op   [4] = '{4'h8, 4'h8, 4'h9, 4'h9};
  logic       b_zero [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       b_pcw  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  wire [38:0] all_out = {alu_op, src_a, src_b, pc_write, pc_src, ir_write, mem_req, mem_write, iord,
                         reg_write, memto_reg, reg_dst, halted, illegal, bus_err, instr_cnt, state};

  always #5 clk = ~clk;

  multicycle_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .input_CLK(clk), .input_Reset_n(rst_n), .input_Opcode(opcode), .input_Zero(zero),
    .input_MemReady(mem_ready), .output_ALUOp(alu_op), .output_ALUSrcA(src_a),
    .output_ALUSrcB(src_b), .output_PCWrite(pc_write), .output_PCSrc(pc_src),
    .output_IRWrite(ir_write), .output_MemReq(mem_req), .output_MemWrite(mem_write),
    .output_IorD(iord), .output_RegWrite(reg_write), .output_MemtoReg(memto_reg),
    .output_RegDst(reg_dst), .output_Halted(halted), .output_Illegal(illegal),
    .output_BusError(bus_err), .output_InstrCount(instr_cnt), .output_State(state)
  );

  // Pulse reset in the low phase; returns at the next negedge with the DUT in FETCH.
  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #1 got = 64'(all_out); exp = 64'(0);
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    #1 got = 64'(state); exp = 64'(ST_IDLE);
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_idle got=%h exp=%h", got, exp); end
    @(negedge clk);
    #1 got = 64'({state, mem_req}); exp = 64'({ST_FETCH, 1'b1});
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_fetch got=%h exp=%h", got, exp); end
    #2 mem_ready = 1'b1; rst_n = 1'b0;
    #1 got = 64'(all_out); exp = 64'(0);
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_async got=%h exp=%h", got, exp); end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0;
    #1 got = 64'(state); exp = 64'(ST_IDLE);
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_idle2 got=%h exp=%h", got, exp); end
    @(negedge clk);
    #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'd0});
    checks++; if (got !== exp) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", got, exp); end
    exp_cnt = 0;
  endtask

  task automatic test_sub();
    opcode = 4'h1; mem_ready = 1'b1;
    #1 got = 64'({state, ir_write, pc_write, mem_req, iord, src_a, src_b, alu_op, pc_src});
    exp = 64'({ST_FETCH, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 2'b00});
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_fetch got=%h exp=%h", got, exp); end
    @(negedge clk);
    #1 got = 64'({state, src_a, src_b, alu_op}); exp = 64'({ST_DECODE, 1'b0, 2'b10, 3'b000});
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_decode got=%h exp=%h", got, exp); end
    @(negedge clk); opcode = 4'h2;
    #1 got = 64'({state, src_a, src_b, alu_op}); exp = 64'({ST_EXEC_R, 1'b1, 2'b00, 3'b001});
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_exec got=%h exp=%h", got, exp); end
    @(negedge clk);
    #1 got = 64'({state, reg_write, reg_dst, memto_reg, instr_cnt}); exp = 64'({ST_ALU_WB, 1'b1, 1'b1, 1'b0, 16'd0});
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_wb got=%h exp=%h", got, exp); end
    @(negedge clk); exp_cnt++;
    #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'(exp_cnt)});
    checks++; if (got !== exp) begin failures++; $display("FAIL sub_retire got=%h exp=%h", got, exp); end
  endtask

  task automatic test_load_wait();
    opcode = 4'h6; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    #1 got = 64'({state, src_a, src_b, alu_op}); exp = 64'({ST_MEM_ADDR, 1'b1, 2'b10, 3'b000});
    checks++; if (got !== exp) begin failures++; $display("FAIL lw_addr got=%h exp=%h", got, exp); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3);
      #1 got = 64'({state, mem_req, iord, mem_write, reg_write}); exp = 64'({ST_MEM_RD, 1'b1, 1'b1, 1'b0, 1'b0});
      checks++; if (got !== exp) begin failures++; $display("FAIL lw_rd%0d got=%h exp=%h", i, got, exp); end
    end
    @(negedge clk);
    #1 got = 64'({state, reg_write, memto_reg, reg_dst, mem_req}); exp = 64'({ST_MEM_WB, 1'b1, 1'b1, 1'b0, 1'b0});
    checks++; if (got !== exp) begin failures++; $display("FAIL lw_wb got=%h exp=%h", got, exp); end
    @(negedge clk); exp_cnt++;
    #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'(exp_cnt)});
    checks++; if (got !== exp) begin failures++; $display("FAIL lw_retire got=%h exp=%h", got, exp); end
  endtask

  task automatic test_store_jump();
    opcode = 4'h7; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 got = 64'({state, mem_req, mem_write, iord}); exp = 64'({ST_MEM_WR, 1'b1, 1'b1, 1'b1});
    checks++; if (got !== exp) begin failures++; $display("FAIL sw_wr got=%h exp=%h", got, exp); end
    @(negedge clk); exp_cnt++; opcode = 4'hA;
    #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'(exp_cnt)});
    checks++; if (got !== exp) begin failures++; $display("FAIL sw_retire got=%h exp=%h", got, exp); end
    @(negedge clk);
    @(negedge clk);
    #1 got = 64'({state, pc_write, pc_src}); exp = 64'({ST_JUMP, 1'b1, 2'b10});
    checks++; if (got !== exp) begin failures++; $display("FAIL j_jump got=%h exp=%h", got, exp); end
    @(negedge clk); exp_cnt++;
    #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'(exp_cnt)});
    checks++; if (got !== exp) begin failures++; $display("FAIL j_retire got=%h exp=%h", got, exp); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      opcode = b_op[i]; mem_ready = 1'b1; zero = 1'b0;
      @(negedge clk);
      @(negedge clk); zero = b_zero[i];
      #1 got = 64'({state, pc_write, pc_src, alu_op, src_a, src_b});
      exp = 64'({ST_BRANCH, b_pcw[i], 2'b01, 3'b001, 1'b1, 2'b00});
      checks++; if (got !== exp) begin failures++; $display("FAIL branch%0d got=%h exp=%h", i, got, exp); end
      @(negedge clk); exp_cnt++;
      #1 got = 64'({state, instr_cnt}); exp = 64'({ST_FETCH, 16'(exp_cnt)});
      checks++; if (got !== exp) begin failures++; $display("FAIL branch%0d_retire got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_illegal();
    opcode = 4'hC; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1 got = 64'({state, halted, illegal, bus_err, pc_write, mem_req, instr_cnt});
      exp = 64'({ST_HALT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'(exp_cnt)});
      checks++; if (got !== exp) begin failures++; $display("FAIL illegal_hold%0d got=%h exp=%h", i, got, exp); end
      @(negedge clk);
    end
    do_reset();
    #1 got = 64'({state, illegal, halted, instr_cnt}); exp = 64'({ST_FETCH, 1'b0, 1'b0, 16'd0});
    checks++; if (got !== exp) begin failures++; $display("FAIL illegal_exit got=%h exp=%h", got, exp); end
  endtask

  task automatic test_halt_op();
    opcode = 4'h0; mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    exp_cnt++;
    opcode = 4'hF;
    @(negedge clk);
    @(negedge clk);
    repeat (2) begin
      #1 got = 64'({state, halted, illegal, bus_err, instr_cnt}); exp = 64'({ST_HALT, 1'b1, 1'b0, 1'b0, 16'(exp_cnt)});
      checks++; if (got !== exp) begin failures++; $display("FAIL halt_op got=%h exp=%h", got, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      #1 got = 64'({state, bus_err, ir_write}); exp = 64'({ST_FETCH, 1'b0, 1'b0});
      checks++; if (got !== exp) begin failures++; $display("FAIL tmo_wait%0d got=%h exp=%h", i, got, exp); end
      @(negedge clk);
    end
    #1 got = 64'({state, halted, bus_err, illegal}); exp = 64'({ST_HALT, 1'b1, 1'b1, 1'b0});
    checks++; if (got !== exp) begin failures++; $display("FAIL tmo_halt got=%h exp=%h", got, exp); end
    do_reset();
    repeat (14) @(negedge clk);
    mem_ready = 1'b1;
    #1 got = 64'({state, ir_write}); exp = 64'({ST_FETCH, 1'b1});
    checks++; if (got !== exp) begin failures++; $display("FAIL tmo_edge_fetch got=%h exp=%h", got, exp); end
    @(negedge clk);
    #1 got = 64'({state, bus_err, halted}); exp = 64'({ST_DECODE, 1'b0, 1'b0});
    checks++; if (got !== exp) begin failures++; $display("FAIL tmo_edge_decode got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_load_wait();
    test_store_jump();
    test_branch();
    test_illegal();
    test_halt_op();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore/Mealy FSM that sequences the 16-bit multi-cycle datapath: instruction fetch, decode, ALU execute, memory access, and register writeback.
- Drives the shared ALU's operation code and operand-select muxes, plus the PC, IR, memory and register-file enables.
- Consumes the ALU zero flag for branches.
- Keeps a retired-instruction counter and a memory-wait timeout.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, max consecutive cycles waiting on input_MemReady before bus error (≥1)

Ports:
- input_CLK  in  1  system clock, rising edge
- input_Reset_n  in  1  asynchronous active-low reset
- input_Opcode  in  4  IR[15:12], valid from DECODE onward
- input_Zero  in  1  ALU zero flag (same cycle)
- input_MemReady  in  1  memory completes current request this cycle
- output_ALUOp  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
- output_ALUSrcA  out  1  0 PC, 1 regA
- output_ALUSrcB  out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 reserved
- output_PCWrite  out  1  load PC
- output_PCSrc  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
- output_IRWrite  out  1  load IR
- output_MemReq  out  1  memory request
- output_MemWrite  out  1  request is a write
- output_IorD  out  1  address: 0 PC, 1 ALUOut
- output_RegWrite  out  1  register file write
- output_MemtoReg  out  1  writeback data: 0 ALUOut, 1 MDR
- output_RegDst  out  1  0 rt field, 1 rd field
- output_Halted  out  1  core stopped
- output_Illegal  out  1  illegal opcode caused halt (sticky)
- output_BusError  out  1  memory timeout caused halt (sticky)
- output_InstrCount  out  CNT_W  retired instructions
- output_State  out  4  current state (debug)

Behaviour:
- Reset: asynchronous on input_Reset_n low. State=IDLE, counter, wait counter and sticky flags cleared. While in reset every output is 0.
- IDLE: all controls 0; unconditionally goes to FETCH next cycle.
- Opcodes: 0–4 R-type (ADD/SUB/AND/OR/XOR, ALUOp = opcode[2:0]); 5 ADDI; 6 LW; 7 SW; 8 BEQ; 9 BNE; A J; F HALT; B–E illegal.
- FETCH:
  - Controls: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSrc=00.
  - IRWrite=PCWrite=input_MemReady (Mealy).
  - Stays in FETCH until MemReady, then goes to DECODE.
- DECODE:
  - Controls: ALUSrcA=0, ALUSrcB=10, ALUOp=ADD (branch target into ALUOut).
  - Next state by opcode: 0–4→EXEC_R; 5→EXEC_I; 6/7→MEM_ADDR; 8/9→BRANCH; A→JUMP; F→HALT; B–E→HALT with Illegal=1.
  - Opcode is latched internally in DECODE; later states use the latched copy.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=opcode[2:0] → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type and 0 for ADDI → FETCH; retire.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemReq=1, IorD=1; on MemReady → MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH; retire.
- MEM_WR: MemReq=1, MemWrite=1, IorD=1; on MemReady → FETCH; retire.
- BRANCH:
  - Controls: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSrc=01.
  - PCWrite=(BEQ&input_Zero)|(BNE&~input_Zero).
  - → FETCH; retire whether taken or not.
- JUMP: PCWrite=1, PCSrc=10 → FETCH; retire.
- HALT: all controls 0, Halted=1. Absorbing; only reset exits. The HALT opcode itself is not counted.
- Latency, zero-wait memory: R/ADDI 4, LW 5, SW 4, BEQ/BNE/J 3 cycles.
- Retire: InstrCount increments on the cycle leaving the final state. Wraps to 0 after all-ones.
- Timeout:
  - Wait counter increments each cycle in FETCH/MEM_RD/MEM_WR with MemReady=0, and clears on MemReady or any other state.
  - When the count reaches MEM_TIMEOUT with MemReady still 0, next state is HALT with BusError=1.
  - MemReady on the same cycle the limit is reached wins: no error.
- Undriven defaults: ALUOp=ADD, all other controls 0.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD…OP_HALT);
  - ALUOp encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR), kept identical to the ALU's decode;
  - ALUSrcB and PCSrc select encodings;
  - state encodings (4-bit).
- One natural sub-module: mem_wait_timer (wait counter plus timeout compare).
- The FSM's next-state and output decode stay in the top.

Test Plan:
- Reset mid-FETCH with MemReq=1 → all outputs 0 immediately (async); IDLE then FETCH after release; InstrCount=0.
- Opcode 1 (SUB), MemReady always 1 → states FETCH, DECODE, EXEC_R (ALUOp=001), ALU_WB (RegWrite=1, RegDst=1); InstrCount 0→1 after 4 cycles.
- LW with MemReady low for 3 cycles in MEM_RD → MemReq held 3+1 cycles; MEM_WB then asserts RegWrite=1, MemtoReg=1; total 8 cycles.
- BEQ twice: input_Zero=1 → PCWrite=1, PCSrc=01 in BRANCH; input_Zero=0 → PCWrite=0; BNE gives the inverse; each retires (+1).
- Opcode 0xC → Halted=1, Illegal=1 held for 20 cycles; counter unchanged; exits only on reset.
- FETCH with MemReady=0 for 15 cycles → BusError=1, HALT. Repeat with MemReady=1 on the 15th cycle → DECODE, no error.
